// File: rtl/ft_rx_deframer.sv
// rtl/ft_rx_deframer.sv - FT RX FIFO frame deframer with cut-through payload output
//
// Hunts for SYNC_WORD in the RX FIFO stream, reads LEN, forwards LEN payload
// words to a valid/ready sink, then compares the trailing CHK word with the
// 16-bit running sum of payload bits [15:0].
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ft_dout_i/_be_i      FIFO head word and its byte enables (first-word-fall-through)
//   ft_dout_empty_i      1 = no head word
//   ft_dout_get_o        pop head word (combinational)
//   m_data_o/m_be_o      payload word and byte enables
//   m_valid_o/m_last_o   payload valid / final payload word of the frame
//   m_ready_i            sink accepts payload word
//   frame_ok_o/_err_o    one-cycle frame status pulses
//   err_code_o           1 length, 2 checksum, 3 byte enable; held until next error
//   frame_count_o        good frame counter (wraps)

module ft_rx_deframer #(
  parameter int          BUS_WIDTH = 16,
  parameter logic [15:0] SYNC_WORD = 16'hA55A,
  parameter int          MAX_LEN   = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BUS_WIDTH-1:0]   ft_dout_i,
  input  logic [BUS_WIDTH/8-1:0] ft_dout_be_i,
  input  logic                   ft_dout_empty_i,
  output logic                   ft_dout_get_o,
  output logic [BUS_WIDTH-1:0]   m_data_o,
  output logic [BUS_WIDTH/8-1:0] m_be_o,
  output logic                   m_valid_o,
  output logic                   m_last_o,
  input  logic                   m_ready_i,
  output logic                   frame_ok_o,
  output logic                   frame_err_o,
  output logic [1:0]             err_code_o,
  output logic [15:0]            frame_count_o
);

  localparam int          BEW       = BUS_WIDTH / 8;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_BE  = 2'd3;

  typedef enum logic [1:0] {
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
    S_CHECK
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          chk_q, chk_d;
  logic [BUS_WIDTH-1:0] m_data_q, m_data_d;
  logic [BEW-1:0]       m_be_q, m_be_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic                 frame_ok_q, frame_ok_d;
  logic                 frame_err_q, frame_err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 pop;

  logic [15:0] head_word;
  logic        be_full;

  assign head_word = ft_dout_i[15:0];
  assign be_full   = &ft_dout_be_i;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    chk_d         = chk_q;
    m_data_d      = m_data_q;
    m_be_d        = m_be_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    frame_ok_d    = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    frame_count_d = frame_count_q;
    pop           = 1'b0;

    // Acceptance retires the held word; a pop below in the same cycle
    // overrides this with the next word, which keeps 1 word/cycle.
    if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      S_SYNC: begin
        pop = !ft_dout_empty_i;
        if (pop && head_word == SYNC_WORD && be_full) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        pop = !ft_dout_empty_i;
        if (pop) begin
          if (!be_full) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BE;
            state_d     = S_SYNC;
          end else if (head_word > MAX_LEN_W) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_SYNC;
          end else begin
            cnt_d   = head_word;
            chk_d   = 16'd0;
            state_d = (head_word == 16'd0) ? S_CHECK : S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        // Only pop when the output register is free or being drained now.
        pop = !ft_dout_empty_i && (!m_valid_q || m_ready_i);
        if (pop) begin
          m_data_d  = ft_dout_i;
          m_be_d    = ft_dout_be_i;
          m_valid_d = 1'b1;
          m_last_d  = (cnt_q == 16'd1);
          chk_d     = chk_q + head_word;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        // Does not wait for the last payload word to drain.
        pop = !ft_dout_empty_i;
        if (pop) begin
          state_d = S_SYNC;
          if (!be_full) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BE;
          end else if (head_word != chk_q) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end else begin
            frame_ok_d    = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_SYNC;
      cnt_q         <= 16'd0;
      chk_q         <= 16'd0;
      m_data_q      <= '0;
      m_be_q        <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      chk_q         <= chk_d;
      m_data_q      <= m_data_d;
      m_be_q        <= m_be_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Gated by rst_n so the FIFO is never popped while reset is asserted.
  assign ft_dout_get_o = pop && rst_n;
  assign m_data_o      = m_data_q;
  assign m_be_o        = m_be_q;
  assign m_valid_o     = m_valid_q;
  assign m_last_o      = m_last_q;
  assign frame_ok_o    = frame_ok_q;
  assign frame_err_o   = frame_err_q;
  assign err_code_o    = err_code_q;
  assign frame_count_o = frame_count_q;

endmodule
